// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: requester and MAC TX stream bundle around the arbiter
interface eth_tx_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KEEP_W-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic              s0_tlast, s1_tlast, m_tlast;
  logic              s0_tvalid, s1_tvalid, m_tvalid;
  logic              s0_tready, s1_tready, m_tready;
  logic [1:0]        grant;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;
  modport slave (
    input  s0_tdata, s0_tkeep, s0_tlast, s0_tvalid,
    input  s1_tdata, s1_tkeep, s1_tlast, s1_tvalid, m_tready,
    output s0_tready, s1_tready, m_tdata, m_tkeep, m_tlast, m_tvalid,
    output grant, pkt_cnt0, pkt_cnt1
  );
  modport master (
    output s0_tdata, s0_tkeep, s0_tlast, s0_tvalid,
    output s1_tdata, s1_tkeep, s1_tlast, s1_tvalid, m_tready,
    input  s0_tready, s1_tready, m_tdata, m_tkeep, m_tlast, m_tvalid,
    input  grant, pkt_cnt0, pkt_cnt1
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: two-requester packet-locked round-robin arbiter onto a registered MAC TX stream
module eth_tx_arbiter #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int CNT_W  = 32
) (
  input logic aclk,
  input logic aresetn,
  eth_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t            state, nxt;
  logic              last_srv, src, rdy, own_valid, own_last, acc;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast, tvalid;
  logic [CNT_W-1:0]  cnt0, cnt1;
  // owner selection, accept decode and next state; IDLE always costs one cycle per packet
  always_comb begin
    rdy = ~tvalid | bus.m_tready;
    own_valid = state == GNT1 ? bus.s1_tvalid : state == GNT0 ? bus.s0_tvalid : 1'b0;
    own_last = state == GNT1 ? bus.s1_tlast : bus.s0_tlast;
    acc = own_valid & rdy;
    nxt = state;
    if (state == IDLE)
      nxt = bus.s0_tvalid & bus.s1_tvalid ? (last_srv ? GNT0 : GNT1) :
            bus.s0_tvalid ? GNT0 : bus.s1_tvalid ? GNT1 : IDLE;
    else if (acc & own_last)
      nxt = IDLE;
  end
  // state register; last-served pointer moves only when a packet is granted
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      last_srv <= 1'b1;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt != IDLE) last_srv <= nxt == GNT1;
    end
  end
  // output register; src remembers which requester the held flit came from
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tvalid <= 1'b0;
      tdata <= '0;
      tkeep <= '0;
      tlast <= 1'b0;
      src <= 1'b0;
    end else if (acc) begin
      tvalid <= 1'b1;
      tdata <= state == GNT1 ? bus.s1_tdata : bus.s0_tdata;
      tkeep <= state == GNT1 ? bus.s1_tkeep : bus.s0_tkeep;
      tlast <= own_last;
      src <= state == GNT1;
    end else if (bus.m_tready) begin
      tvalid <= 1'b0;
    end
  end
  // per-requester packet counters, bumped when a tlast flit leaves the output
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (tvalid & bus.m_tready & tlast) begin
      if (src) cnt1 <= cnt1 + 1'b1;
      else cnt0 <= cnt0 + 1'b1;
    end
  end
  assign bus.s0_tready = state == GNT0 & rdy;
  assign bus.s1_tready = state == GNT1 & rdy;
  assign bus.grant = {state == GNT1, state == GNT0};
  assign bus.m_tdata = tdata;
  assign bus.m_tkeep = tkeep;
  assign bus.m_tlast = tlast;
  assign bus.m_tvalid = tvalid;
  assign bus.pkt_cnt0 = cnt0;
  assign bus.pkt_cnt1 = cnt1;
endmodule
